// File: rtl/ex_sched_pkg.sv
// ex_sched_pkg: shared state type and constants for the execute-stage hazard scheduler
package ex_sched_pkg;
  typedef enum logic {RUN, MC_WAIT} sched_state_t;
  localparam int REG_W_DEF = 5;
  localparam logic [4:0] XZR = 5'd31;
endpackage

// File: rtl/ex_hazard_scheduler_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk)
    r_q <= i_clr ? '0 : (i_en && !(&r_q)) ? r_q + 1'b1 : r_q;
  assign o_q = r_q;
endmodule

// File: rtl/ex_hazard_scheduler.sv
// ex_hazard_scheduler: stall/flush sequencing for branch flush, multicycle EX ops and load-use hazards
module ex_hazard_scheduler
  import ex_sched_pkg::*;
#(
  parameter int REG_W      = REG_W_DEF,
  parameter int CNT_W      = 16,
  parameter int MC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] i_id_rn,
  input  logic [REG_W-1:0] i_id_rm,
  input  logic             i_id_uses_rm,
  input  logic             i_ex_memRead,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_mc_start,
  input  logic             i_mc_done,
  input  logic             i_mem_branch_taken,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_idex_en,
  output logic             o_flush_ifid,
  output logic             o_flush_idex,
  output logic             o_flush_exmem,
  output logic             o_mc_go,
  output logic             o_mc_abort,
  output logic             o_mc_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);
  localparam int WD_W = $clog2(MC_TIMEOUT);
  sched_state_t    r_state, w_next;
  logic [WD_W-1:0] r_wdog;
  logic            r_mc_err;
  logic            w_load_use, w_timeout, w_flush_ev;
  assign w_load_use = i_ex_memRead && (i_ex_rd != REG_W'(XZR)) &&
                      (i_ex_rd == i_id_rn || (i_id_uses_rm && i_ex_rd == i_id_rm));
  always_comb begin
    o_pc_en       = 1'b1;
    o_ifid_en     = 1'b1;
    o_idex_en     = 1'b1;
    o_flush_ifid  = 1'b0;
    o_flush_idex  = 1'b0;
    o_flush_exmem = 1'b0;
    o_mc_go       = 1'b0;
    o_mc_abort    = 1'b0;
    w_timeout     = 1'b0;
    w_next        = r_state;
    if (reset) begin
      if (r_state == RUN) begin
        if (i_mem_branch_taken) begin
          {o_flush_ifid, o_flush_idex, o_flush_exmem} = 3'b111;
        end else if (i_ex_mc_start) begin
          {o_pc_en, o_ifid_en, o_idex_en} = 3'b000;
          o_flush_exmem = 1'b1;
          o_mc_go       = 1'b1;
          w_next        = MC_WAIT;
        end else if (w_load_use) begin
          {o_pc_en, o_ifid_en} = 2'b00;
          o_flush_idex = 1'b1;
        end
      end else begin
        // a squashed or timed-out op never produces a result, so EX/MEM gets a bubble
        if (i_mem_branch_taken) begin
          {o_flush_ifid, o_flush_idex, o_flush_exmem} = 3'b111;
          o_mc_abort = 1'b1;
          w_next     = RUN;
        end else if (i_mc_done) begin
          w_next = RUN;
        end else if (r_wdog == WD_W'(MC_TIMEOUT - 1)) begin
          o_flush_exmem = 1'b1;
          o_mc_abort    = 1'b1;
          w_timeout     = 1'b1;
          w_next        = RUN;
        end else begin
          {o_pc_en, o_ifid_en, o_idex_en} = 3'b000;
          o_flush_exmem = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= RUN;
      r_wdog   <= '0;
      r_mc_err <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_wdog   <= (r_state == MC_WAIT && w_next == MC_WAIT) ? r_wdog + 1'b1 : '0;
      r_mc_err <= r_mc_err | w_timeout;
    end
  end
  assign o_mc_err   = r_mc_err;
  assign w_flush_ev = reset && i_mem_branch_taken;
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .i_en(!o_pc_en), .i_clr(!reset), .o_q(o_stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .i_en(w_flush_ev), .i_clr(!reset), .o_q(o_flush_cnt));
endmodule

// File: tb/tb_ex_hazard_scheduler.sv
// tb_ex_hazard_scheduler: per-cycle scoreboard of control outputs plus a saturating counter model
module tb_ex_hazard_scheduler;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rn, id_rm, ex_rd;
  logic        id_uses_rm, ex_memRead, ex_mc_start, mc_done, mem_branch_taken;
  logic        pc_en, ifid_en, idex_en, flush_ifid, flush_idex, flush_exmem, mc_go, mc_abort, mc_err;
  logic [15:0] stall_cnt, flush_cnt;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] m_stall, m_flush;
  typedef struct {
    string      tag;
    logic [8:0] exp;
    logic [8:0] mask;
  } ent_t;
  ent_t sb[$];
  // {pc_en, ifid_en, idex_en, flush_ifid, flush_idex, flush_exmem, mc_go, mc_abort, mc_err}
  localparam logic [8:0] NORM = 9'b111_000_00_0;
  localparam logic [8:0] LU   = 9'b001_010_00_0;
  localparam logic [8:0] MCGO = 9'b000_001_10_0;
  localparam logic [8:0] MCW  = 9'b000_001_00_0;
  localparam logic [8:0] BR   = 9'b111_111_00_0;
  localparam logic [8:0] MCBR = 9'b111_111_01_0;
  localparam logic [8:0] TO   = 9'b111_000_01_0;
  localparam logic [8:0] TOM  = 9'b111_000_111;
  localparam logic [8:0] ERR  = 9'b000_000_00_1;

  ex_hazard_scheduler dut (
    .clk(clk), .reset(reset), .i_id_rn(id_rn), .i_id_rm(id_rm), .i_id_uses_rm(id_uses_rm),
    .i_ex_memRead(ex_memRead), .i_ex_rd(ex_rd), .i_ex_mc_start(ex_mc_start), .i_mc_done(mc_done),
    .i_mem_branch_taken(mem_branch_taken), .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_idex_en(idex_en),
    .o_flush_ifid(flush_ifid), .o_flush_idex(flush_idex), .o_flush_exmem(flush_exmem),
    .o_mc_go(mc_go), .o_mc_abort(mc_abort), .o_mc_err(mc_err),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [4:0] rn, input logic [4:0] rm, input logic urm,
                     input logic mr, input logic [4:0] rd, input logic st, input logic dn,
                     input logic br, input logic rs, input logic [8:0] exp,
                     input logic [8:0] mask = 9'h1FF);
    ent_t e;
    @(posedge clk);
    #1;
    id_rn = rn; id_rm = rm; id_uses_rm = urm; ex_memRead = mr; ex_rd = rd;
    ex_mc_start = st; mc_done = dn; mem_branch_taken = br; reset = rs;
    sb.push_back('{tag, exp, mask});
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, "_ctl"}, 32'({pc_en, ifid_en, idex_en, flush_ifid, flush_idex, flush_exmem,
                              mc_go, mc_abort, mc_err} & e.mask), 32'(e.exp & e.mask));
    chk({e.tag, "_stall"}, 32'(stall_cnt), 32'(m_stall));
    chk({e.tag, "_flush"}, 32'(flush_cnt), 32'(m_flush));
    if (!rs) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (!e.exp[8] && m_stall != 16'hFFFF) m_stall = m_stall + 1'b1;
      if (e.exp[5] && m_flush != 16'hFFFF) m_flush = m_flush + 1'b1;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; id_rn = '0; id_rm = '0; id_uses_rm = 1'b0; ex_memRead = 1'b0; ex_rd = '0;
    ex_mc_start = 1'b0; mc_done = 1'b0; mem_branch_taken = 1'b0;
    m_stall = '0; m_flush = '0;
    repeat (2) @(posedge clk);
    //             rn  rm urm mr rd  st dn br rs
    cyc("idle",     0,  0, 0, 0,  0, 0, 0, 0, 1, NORM);
    cyc("lu_rn",    1,  3, 1, 1,  1, 0, 0, 0, 1, LU);
    cyc("lu_clear", 2,  1, 1, 0,  0, 0, 0, 0, 1, NORM);
    cyc("lu_rm",    4,  5, 1, 1,  5, 0, 0, 0, 1, LU);
    cyc("xzr",     31,  0, 0, 1, 31, 0, 0, 0, 1, NORM);
    cyc("rm_unused",2,  1, 0, 1,  1, 0, 0, 0, 1, NORM);
    cyc("no_load",  1,  1, 1, 0,  1, 0, 0, 0, 1, NORM);
    cyc("mc_go",    1,  0, 0, 1,  1, 1, 0, 0, 1, MCGO);
    cyc("mc_w1",    0,  0, 0, 0,  0, 1, 0, 0, 1, MCW);
    cyc("mc_w2",    0,  0, 0, 0,  0, 0, 0, 0, 1, MCW);
    cyc("mc_done",  0,  0, 0, 0,  0, 0, 1, 0, 1, NORM);
    cyc("done_run", 0,  0, 0, 0,  0, 0, 1, 0, 1, NORM);
    cyc("br_mc",    0,  0, 0, 0,  0, 1, 0, 1, 1, BR);
    cyc("br_after", 0,  0, 0, 0,  0, 0, 0, 0, 1, NORM);
    cyc("br_lu",    1,  0, 0, 1,  1, 0, 0, 1, 1, BR);
    cyc("mc_go2",   0,  0, 0, 0,  0, 1, 0, 0, 1, MCGO);
    cyc("mc_br",    0,  0, 0, 0,  0, 0, 1, 1, 1, MCBR);
    cyc("abort_run",0,  0, 0, 0,  0, 0, 0, 0, 1, NORM);
    cyc("mc_go3",   0,  0, 0, 0,  0, 1, 0, 0, 1, MCGO);
    for (int i = 0; i < 63; i++) cyc("wd_wait", 0, 0, 0, 0, 0, 0, 0, 0, 1, MCW);
    cyc("wd_abort", 0,  0, 0, 0,  0, 0, 0, 0, 1, TO, TOM);
    cyc("err_run",  0,  0, 0, 0,  0, 0, 0, 0, 1, NORM | ERR);
    cyc("err_lu",   1,  0, 0, 1,  1, 0, 0, 0, 1, LU | ERR);
    cyc("mc_go4",   0,  0, 0, 0,  0, 1, 0, 0, 1, MCGO | ERR);
    cyc("mc_w4",    0,  0, 0, 0,  0, 0, 0, 0, 1, MCW | ERR);
    cyc("rst_mcw",  0,  0, 0, 0,  0, 1, 0, 1, 0, NORM | ERR);
    cyc("post_rst", 0,  0, 0, 0,  0, 0, 0, 0, 1, NORM);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);
    for (int i = 0; i < 65534; i++) cyc("sat_fill", 1, 0, 0, 1, 1, 0, 0, 0, 1, LU);
    cyc("sat_edge", 1,  0, 0, 1,  1, 0, 0, 0, 1, LU);
    chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
    cyc("sat_s2",   1,  0, 0, 1,  1, 0, 0, 0, 1, LU);
    cyc("sat_s3",   1,  0, 0, 1,  1, 0, 0, 0, 1, LU);
    cyc("sat_hold", 0,  0, 0, 0,  0, 0, 0, 0, 1, NORM);
    chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
